rtc_counter: RTL and testbench

Parametrised real-time HH:MM:SS counter for the board-level clock designs. It divides the board clock down to a 1 Hz tick and counts time up or down, supporting 24 h and 12 h presentation, per-field synchronous load, and an HH:MM alarm. It sits between the board clock input and the per-digit 7-segment decoders, which consume `hr`, `min`, and `sec` in binary.

---
 rtl/rtc_pkg.sv | 32 +++
 rtl/rtc_prescaler.sv | 37 +++
 rtl/rtc_counter.sv | 158 +++++++++++++++
 tb/tb_rtc_counter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared widths, field maxima, load-select encodings and the 12 h hour
// mapping used by the real-time counter and its bench.
// Ports: none (package).
package rtc_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

    typedef enum logic [1:0] {
        LD_SEC = 2'd0,
        LD_MIN = 2'd1,
        LD_HR  = 2'd2,
        LD_CLR = 2'd3
    } ld_sel_e;

    // 24 h -> 12 h presentation: 0 -> 12, 13..23 -> 1..11.
    function automatic logic [HR_W-1:0] hr_to_12(input logic [HR_W-1:0] h24);
        if (h24 == '0) begin
            return 5'd12;
        end else if (h24 > 5'd12) begin
            return h24 - 5'd12;
        end else begin
            return h24;
        end
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides clk down to one tick_pre cycle every TICK_DIV enabled cycles.
// Ports:
//   clk      in  system clock
//   preset   in  asynchronous active-high reset
//   en       in  count enable; count holds when low
//   clr      in  synchronous clear of the count
//   stall    in  force and hold the count at 0, suppress tick_pre
//   tick_pre out combinational, high on the cycle whose edge completes a period
module rtc_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic preset,
    input  logic en,
    input  logic clr,
    input  logic stall,
    output logic tick_pre
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick_pre = en && !stall && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            r_cnt <= '0;
        end else if (clr || stall) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rtc_counter.sv
// rtc_counter: HH:MM:SS real-time counter (up / saturating down) with per-field load,
// 12 h presentation and an HH:MM alarm.
// Ports:
//   clk, preset              clock, asynchronous active-high reset
//   en, down                 count enable, direction (1 = down)
//   mode12                   12 h presentation of hr / pm
//   load, load_sel, load_val single-cycle field load (sel 3 clears all fields)
//   alarm_en/hr/min          alarm arm and HH:MM compare value
//   hr, min, sec             presented time
//   pm                       hour >= 12 in 12 h mode
//   tick, alarm              one-cycle registered pulses
//   zero                     internal time is 00:00:00
module rtc_counter
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV         = 50_000_000,
    parameter bit          LOAD_RESETS_TICK = 1'b1
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             en,
    input  logic             down,
    input  logic             mode12,
    input  logic             load,
    input  logic [1:0]       load_sel,
    input  logic [5:0]       load_val,
    input  logic             alarm_en,
    input  logic [HR_W-1:0]  alarm_hr,
    input  logic [MIN_W-1:0] alarm_min,
    output logic [HR_W-1:0]  hr,
    output logic [MIN_W-1:0] min,
    output logic [SEC_W-1:0] sec,
    output logic             pm,
    output logic             tick,
    output logic             alarm,
    output logic             zero
);

    logic [SEC_W-1:0] r_sec;
    logic [MIN_W-1:0] r_min;
    logic [HR_W-1:0]  r_hr;
    logic             r_tick;
    logic             r_alarm;

    logic             w_zero;
    logic             w_stall;
    logic             w_load_ok;
    logic             w_tick_pre;
    logic             w_alarm_hit;
    logic [SEC_W-1:0] w_nsec;
    logic [MIN_W-1:0] w_nmin;
    logic [HR_W-1:0]  w_nhr;

    assign w_zero  = (r_sec == '0) && (r_min == '0) && (r_hr == '0);
    // Counting down into 00:00:00 saturates: prescaler parked at 0, no ticks.
    assign w_stall = down && w_zero;

    // Out-of-range values are dropped completely, including the prescaler clear.
    always_comb begin
        w_load_ok = 1'b0;
        if (load) begin
            unique case (ld_sel_e'(load_sel))
                LD_SEC: w_load_ok = (load_val <= SEC_MAX);
                LD_MIN: w_load_ok = (load_val <= MIN_MAX);
                LD_HR:  w_load_ok = (load_val <= 6'(HR_MAX));
                LD_CLR: w_load_ok = 1'b1;
            endcase
        end
    end

    rtc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .preset   (preset),
        .en       (en),
        .clr      (w_load_ok && LOAD_RESETS_TICK),
        .stall    (w_stall),
        .tick_pre (w_tick_pre)
    );

    // Time one second after the current one in the selected direction.
    always_comb begin
        w_nsec = r_sec;
        w_nmin = r_min;
        w_nhr  = r_hr;
        if (!down) begin
            if (r_sec == SEC_MAX) begin
                w_nsec = '0;
                if (r_min == MIN_MAX) begin
                    w_nmin = '0;
                    w_nhr  = (r_hr == HR_MAX) ? '0 : r_hr + 5'd1;
                end else begin
                    w_nmin = r_min + 6'd1;
                end
            end else begin
                w_nsec = r_sec + 6'd1;
            end
        end else begin
            if (r_sec == '0) begin
                w_nsec = SEC_MAX;
                if (r_min == '0) begin
                    w_nmin = MIN_MAX;
                    // hr == 0 here only at 00:00:00, which is stalled.
                    w_nhr  = (r_hr == '0) ? '0 : r_hr - 5'd1;
                end else begin
                    w_nmin = r_min - 6'd1;
                end
            end else begin
                w_nsec = r_sec - 6'd1;
            end
        end
    end

    assign w_alarm_hit = alarm_en && (w_nhr == alarm_hr) && (w_nmin == alarm_min)
                         && (w_nsec == '0);

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            r_sec   <= '0;
            r_min   <= '0;
            r_hr    <= '0;
            r_tick  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_alarm <= 1'b0;
            if (w_load_ok) begin
                // Load beats a coincident tick; that second is dropped.
                unique case (ld_sel_e'(load_sel))
                    LD_SEC: r_sec <= load_val;
                    LD_MIN: r_min <= load_val;
                    LD_HR:  r_hr  <= load_val[HR_W-1:0];
                    LD_CLR: begin
                        r_sec <= '0;
                        r_min <= '0;
                        r_hr  <= '0;
                    end
                endcase
            end else if (w_tick_pre) begin
                r_sec   <= w_nsec;
                r_min   <= w_nmin;
                r_hr    <= w_nhr;
                r_tick  <= 1'b1;
                r_alarm <= w_alarm_hit;
            end
        end
    end

    assign hr    = mode12 ? hr_to_12(r_hr) : r_hr;
    assign pm    = mode12 && (r_hr >= 5'd12);
    assign min   = r_min;
    assign sec   = r_sec;
    assign tick  = r_tick;
    assign alarm = r_alarm;
    assign zero  = w_zero;

endmodule

// File: tb/tb_rtc_counter.sv
// tb_rtc_counter: directed scenarios plus randomized stimulus, checked every cycle
// against a seconds-of-day reference model.
module tb_rtc_counter;

    localparam int unsigned DIV = 4;
    localparam int DAY = 86400;

    logic       clk;
    logic       preset;
    logic       en;
    logic       down;
    logic       mode12;
    logic       load;
    logic [1:0] load_sel;
    logic [5:0] load_val;
    logic       alarm_en;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic       pm;
    logic       tick;
    logic       alarm;
    logic       zero;

    rtc_counter #(
        .TICK_DIV         (DIV),
        .LOAD_RESETS_TICK (1'b1)
    ) dut (
        .clk       (clk),
        .preset    (preset),
        .en        (en),
        .down      (down),
        .mode12    (mode12),
        .load      (load),
        .load_sel  (load_sel),
        .load_val  (load_val),
        .alarm_en  (alarm_en),
        .alarm_hr  (alarm_hr),
        .alarm_min (alarm_min),
        .hr        (hr),
        .min       (min),
        .sec       (sec),
        .pm        (pm),
        .tick      (tick),
        .alarm     (alarm),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time as seconds since midnight, prescaler phase as an integer.
    int t;
    int ph;
    bit e_tick;
    bit e_alarm;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        t       = 0;
        ph      = 0;
        e_tick  = 0;
        e_alarm = 0;
    endtask

    task automatic model_step();
        int  h, m, s;
        bit  ok, sat, adv;
        h   = t / 3600;
        m   = (t / 60) % 60;
        s   = t % 60;
        sat = down && (t == 0);
        ok  = 0;
        if (load) begin
            case (load_sel)
                2'd0:    ok = (load_val <= 59);
                2'd1:    ok = (load_val <= 59);
                2'd2:    ok = (load_val <= 23);
                default: ok = 1;
            endcase
        end
        adv = en && !sat && (ph == DIV - 1);
        if (sat) ph = 0;
        else if (en) ph = (ph + 1) % DIV;
        if (ok) ph = 0;
        e_tick  = 0;
        e_alarm = 0;
        if (ok) begin
            case (load_sel)
                2'd0:    s = load_val;
                2'd1:    m = load_val;
                2'd2:    h = load_val;
                default: begin h = 0; m = 0; s = 0; end
            endcase
            t = h * 3600 + m * 60 + s;
        end else if (adv) begin
            t       = down ? t - 1 : (t + 1) % DAY;
            e_tick  = 1;
            e_alarm = alarm_en && (t == alarm_hr * 3600 + alarm_min * 60);
        end
    endtask

    task automatic compare_all();
        int h, h_out;
        h     = t / 3600;
        h_out = !mode12 ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
        check_eq("hr", hr, h_out);
        check_eq("min", min, (t / 60) % 60);
        check_eq("sec", sec, t % 60);
        check_eq("pm", pm, mode12 && h >= 12);
        check_eq("tick", tick, e_tick);
        check_eq("alarm", alarm, e_alarm);
        check_eq("zero", zero, t == 0);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_load(input logic [1:0] sel, input logic [5:0] val);
        load     = 1'b1;
        load_sel = sel;
        load_val = val;
        step();
        load     = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        preset = 1'b1;
        #1;
        model_reset();
        compare_all();
        preset = 1'b0;
    endtask

    int cnt;

    initial begin
        preset    = 1'b1;
        en        = 1'b0;
        down      = 1'b0;
        mode12    = 1'b0;
        load      = 1'b0;
        load_sel  = 2'd0;
        load_val  = 6'd0;
        alarm_en  = 1'b0;
        alarm_hr  = 5'd0;
        alarm_min = 6'd0;
        model_reset();

        // Reset state, both presentations.
        #3;
        compare_all();
        mode12 = 1'b1;
        #1;
        check_eq("reset_hr12", hr, 12);
        compare_all();
        mode12 = 1'b0;
        @(posedge clk);
        #1;
        preset = 1'b0;

        // First tick after TICK_DIV enabled cycles.
        en = 1'b1;
        repeat (3) step();
        check_eq("pre_first_tick", tick, 0);
        step();
        check_eq("first_tick", tick, 1);
        check_eq("first_tick_sec", sec, 1);
        repeat (8) step();
        check_eq("third_sec", sec, 3);

        // Midnight wrap counting up.
        en = 1'b0;
        do_load(2'd2, 6'd23);
        do_load(2'd1, 6'd59);
        do_load(2'd0, 6'd58);
        en = 1'b1;
        repeat (4) step();
        check_eq("wrap_pre_sec", sec, 59);
        repeat (4) step();
        check_eq("wrap_tick", tick, 1);
        check_eq("wrap_zero", zero, 1);
        check_eq("wrap_hr", hr, 0);

        // Count down into saturation.
        en = 1'b0;
        do_load(2'd3, 6'd45);
        do_load(2'd0, 6'd2);
        down = 1'b1;
        en   = 1'b1;
        repeat (8) step();
        check_eq("down_zero", zero, 1);
        cnt = 0;
        repeat (4 * DIV) begin
            step();
            if (tick) cnt++;
        end
        check_eq("sat_ticks", cnt, 0);
        check_eq("sat_sec", sec, 0);
        down = 1'b0;

        // 12 h presentation.
        en     = 1'b0;
        mode12 = 1'b1;
        do_load(2'd2, 6'd0);
        check_eq("h0_hr", hr, 12);
        check_eq("h0_pm", pm, 0);
        do_load(2'd2, 6'd12);
        check_eq("h12_hr", hr, 12);
        check_eq("h12_pm", pm, 1);
        do_load(2'd2, 6'd13);
        check_eq("h13_hr", hr, 1);
        check_eq("h13_pm", pm, 1);
        mode12 = 1'b0;

        // Load coinciding with a tick, then an out-of-range load.
        do_load(2'd3, 6'd0);
        en = 1'b1;
        repeat (5 * DIV) step();
        check_eq("pre_load_sec", sec, 5);
        repeat (DIV - 1) step();
        do_load(2'd0, 6'd30);
        check_eq("load_tick_sec", sec, 30);
        check_eq("load_tick_tick", tick, 0);
        repeat (DIV - 1) step();
        check_eq("post_load_quiet", tick, 0);
        step();
        check_eq("post_load_tick", tick, 1);
        check_eq("post_load_sec", sec, 31);
        en = 1'b0;
        do_load(2'd1, 6'd60);
        check_eq("bad_min_load", min, 0);

        // Alarm armed and disarmed.
        alarm_hr  = 5'd1;
        alarm_min = 6'd0;
        for (int pass = 0; pass < 2; pass++) begin
            alarm_en = (pass == 0);
            en       = 1'b0;
            do_load(2'd3, 6'd0);
            do_load(2'd1, 6'd59);
            do_load(2'd0, 6'd58);
            en  = 1'b1;
            cnt = 0;
            repeat (4 * DIV) begin
                step();
                if (alarm) cnt++;
            end
            check_eq(pass == 0 ? "alarm_armed" : "alarm_disarmed", cnt, pass == 0 ? 1 : 0);
        end

        // Asynchronous reset mid-second.
        repeat (6) step();
        async_reset();

        // Randomized traffic.
        repeat (3000) begin
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 149) == 0) down = ~down;
            if ($urandom_range(0, 49) == 0) mode12 = ~mode12;
            if ($urandom_range(0, 99) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(0, 29) == 0) begin
                alarm_hr  = 5'(t / 3600);
                alarm_min = 6'(((t / 60) + $urandom_range(0, 1)) % 60);
            end
            load     = ($urandom_range(0, 19) == 0);
            load_sel = 2'($urandom_range(0, 3));
            load_val = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(55, 63))
                                                   : 6'($urandom_range(0, 63));
            step();
            load = 1'b0;
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
